stage5_writeback: RTL

Final pipeline stage of the RISC-V core: the writer side of the general-purpose register file port that the decode stage reads from. It accepts completed instructions from the memory stage over a valid/ready handshake and waits for load data from data memory. It formats sub-word loads and drives the register-file write port (`write_enable`, `write_idx`, `write_data`) as a registered one-cycle pulse. It also keeps a retired-instruction counter and a sticky load-timeout flag.

---
 rtl/stage5_writeback.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/stage5_writeback.sv
// stage5_writeback: final (writeback) stage of the RISC-V pipeline.
//
// Accepts completed instructions from the memory stage over a valid/ready
// handshake. Non-loads write their ALU result on the cycle after acceptance.
// Loads park the stage in StWaitLoad until data memory returns mem_rvalid.
// The returned word is then formatted for LB/LH/LW/LBU/LHU and written. If
// LOAD_TIMEOUT edges pass without data, the load is abandoned and a sticky
// flag is set. The register-file write port is registered, and each write
// is a one-cycle pulse.
//
// Ports:
//   clk, reset            pipeline clock; asynchronous active-high reset
//   in_valid / in_ready   handshake from the memory stage
//   alu_result, rd_idx, reg_write_enable, mem_load_enable,
//   load_funct3, load_addr_lo  instruction payload
//   mem_rdata, mem_rvalid  load data returned by data memory
//   write_enable, write_idx, write_data  register-file write port
//   retired               count of completed instructions (wraps)
//   load_timeout          sticky: a load was abandoned
module stage5_writeback #(
  parameter int unsigned LOAD_TIMEOUT = 15  // legal range 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd_idx,
  input  logic        reg_write_enable,
  input  logic        mem_load_enable,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        write_enable,
  output logic [4:0]  write_idx,
  output logic [31:0] write_data,
  output logic [31:0] retired,
  output logic        load_timeout
);

  typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

  localparam logic [7:0] TimeoutCount = LOAD_TIMEOUT[7:0];

  state_e      state_q, state_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_we_q, ld_we_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_addr_q, ld_addr_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        we_q, we_d;
  logic [4:0]  widx_q, widx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] retired_q, retired_d;
  logic        timeout_q, timeout_d;

  logic [15:0] shifted;
  logic [31:0] load_data;

  // Only the low halfword of the shifted word is ever used. For a halfword
  // at addr_lo=3 this leaves the upper byte zero.
  always_comb begin
    shifted = 16'(mem_rdata >> {ld_addr_q, 3'b000});
    unique case (ld_funct3_q)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_data = {24'd0, shifted[7:0]};
      3'd5:    load_data = {16'd0, shifted[15:0]};
      default: load_data = mem_rdata;  // LW and the undefined encodings
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_rd_d     = ld_rd_q;
    ld_we_d     = ld_we_q;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;
    tcnt_d      = tcnt_q;
    we_d        = 1'b0;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    retired_d   = retired_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (mem_load_enable) begin
            ld_rd_d     = rd_idx;
            ld_we_d     = reg_write_enable;
            ld_funct3_d = load_funct3;
            ld_addr_d   = load_addr_lo;
            tcnt_d      = 8'd0;
            state_d     = StWaitLoad;
          end else begin
            we_d      = reg_write_enable && (rd_idx != 5'd0);
            widx_d    = rd_idx;
            wdata_d   = alu_result;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      StWaitLoad: begin
        if (mem_rvalid) begin
          we_d      = ld_we_q && (ld_rd_q != 5'd0);
          widx_d    = ld_rd_q;
          wdata_d   = load_data;
          retired_d = retired_q + 32'd1;
          state_d   = StIdle;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == TimeoutCount) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ld_rd_q     <= 5'd0;
      ld_we_q     <= 1'b0;
      ld_funct3_q <= 3'd0;
      ld_addr_q   <= 2'd0;
      tcnt_q      <= 8'd0;
      we_q        <= 1'b0;
      widx_q      <= 5'd0;
      wdata_q     <= 32'd0;
      retired_q   <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_we_q     <= ld_we_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
      tcnt_q      <= tcnt_d;
      we_q        <= we_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      retired_q   <= retired_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign write_enable = we_q;
  assign write_idx    = widx_q;
  assign write_data   = wdata_q;
  assign retired      = retired_q;
  assign load_timeout = timeout_q;

endmodule
